// File: rtl/scp_io_ctrl.sv
// Buffered multi-channel byte I/O controller: per-channel RX/TX FIFOs between the DATA bus
// and external valid/ready channels. Define SCP_IO_IRQ_EN to build the registered RX-pending IRQ.
module scp_io_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IO_W   = 8,
    parameter int unsigned CH     = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                 CLK,
    input  logic                 AR,
    input  logic                 IOR,
    input  logic                 IOW,
    input  logic [2:0]           CH_SEL,
    inout  wire  [DATA_W-1:0]    DATA,
    output logic                 STALL,
    input  logic [CH*IO_W-1:0]   IN_DATA,
    input  logic [CH-1:0]        IN_VALID,
    output logic [CH-1:0]        IN_READY,
    output logic [CH*IO_W-1:0]   OUT_DATA,
    output logic [CH-1:0]        OUT_VALID,
    input  logic [CH-1:0]        OUT_READY,
    output logic                 IRQ
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [IO_W-1:0] rx_mem [CH][DEPTH];
    logic [IO_W-1:0] tx_mem [CH][DEPTH];
    logic [PW-1:0]   rx_wp [CH];
    logic [PW-1:0]   rx_rp [CH];
    logic [CW-1:0]   rx_cnt [CH];
    logic [PW-1:0]   tx_wp [CH];
    logic [PW-1:0]   tx_rp [CH];
    logic [CW-1:0]   tx_cnt [CH];

    logic [CH-1:0]     rx_push, rx_pop, tx_push, tx_pop, rx_nz, tx_nz, hit;
    logic              sel_ok;
    logic [DATA_W-1:0] rd_data;
    logic              unused_data;

    assign unused_data = ^DATA;
    assign DATA = IOR ? rd_data : {DATA_W{1'bz}};

    always_comb begin
        sel_ok    = int'(CH_SEL) < int'(CH);
        rd_data   = '0;
        STALL     = 1'b0;
        IN_READY  = '0;
        OUT_VALID = '0;
        OUT_DATA  = '0;
        rx_push   = '0;
        rx_pop    = '0;
        tx_push   = '0;
        tx_pop    = '0;
        rx_nz     = '0;
        tx_nz     = '0;
        hit       = '0;
        for (int c = 0; c < int'(CH); c++) begin
            rx_nz[c]     = rx_cnt[c] != '0;
            tx_nz[c]     = tx_cnt[c] != '0;
            IN_READY[c]  = AR & (rx_cnt[c] != FULL);
            OUT_VALID[c] = tx_nz[c];
            OUT_DATA[c*IO_W +: IO_W] = tx_nz[c] ? tx_mem[c][tx_rp[c]] : '0;
            rx_push[c]   = IN_VALID[c] & IN_READY[c];
            tx_pop[c]    = tx_nz[c] & OUT_READY[c];
            hit[c]       = AR & sel_ok & (CH_SEL == 3'(c));
            rx_pop[c]    = hit[c] & IOR & rx_nz[c];
            // A read strobe wins over a simultaneous write strobe.
            tx_push[c]   = hit[c] & ~IOR & IOW & (tx_cnt[c] != FULL);
            if (hit[c] && IOR) begin
                STALL = ~rx_nz[c];
                if (rx_nz[c]) rd_data = DATA_W'(rx_mem[c][rx_rp[c]]);
            end else if (hit[c] && IOW) begin
                STALL = tx_cnt[c] == FULL;
            end
        end
    end

    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            for (int c = 0; c < int'(CH); c++) begin
                rx_wp[c]  <= '0;
                rx_rp[c]  <= '0;
                rx_cnt[c] <= '0;
                tx_wp[c]  <= '0;
                tx_rp[c]  <= '0;
                tx_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(CH); c++) begin
                if (rx_push[c]) rx_wp[c] <= rx_wp[c] + 1'b1;
                if (rx_pop[c])  rx_rp[c] <= rx_rp[c] + 1'b1;
                if (tx_push[c]) tx_wp[c] <= tx_wp[c] + 1'b1;
                if (tx_pop[c])  tx_rp[c] <= tx_rp[c] + 1'b1;
                case ({rx_push[c], rx_pop[c]})
                    2'b10:   rx_cnt[c] <= rx_cnt[c] + 1'b1;
                    2'b01:   rx_cnt[c] <= rx_cnt[c] - 1'b1;
                    default: rx_cnt[c] <= rx_cnt[c];
                endcase
                case ({tx_push[c], tx_pop[c]})
                    2'b10:   tx_cnt[c] <= tx_cnt[c] + 1'b1;
                    2'b01:   tx_cnt[c] <= tx_cnt[c] - 1'b1;
                    default: tx_cnt[c] <= tx_cnt[c];
                endcase
            end
        end
    end

    // Storage needs no reset; emptiness is tracked by the counts.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < int'(CH); c++) begin
            if (rx_push[c]) rx_mem[c][rx_wp[c]] <= IN_DATA[c*IO_W +: IO_W];
            if (tx_push[c]) tx_mem[c][tx_wp[c]] <= DATA[IO_W-1:0];
        end
    end

`ifdef SCP_IO_IRQ_EN
    logic irq_q;
    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) irq_q <= 1'b0;
        else     irq_q <= |rx_nz;
    end
    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_scp_io_ctrl.sv
// Directed bench for scp_io_ctrl (CH=2, DEPTH=4) with RX/TX expected-data queues.
module tb_scp_io_ctrl;

`ifdef SCP_IO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk, ar, ior, iow;
    logic [2:0]  ch_sel;
    logic [15:0] tb_data;
    wire  [15:0] data_bus;
    logic        stall, irq;
    logic [15:0] in_data, out_data;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] exp_b;
    int checks = 0;
    int errors = 0;

    assign data_bus = ior ? 16'hzzzz : tb_data;

    scp_io_ctrl #(.DATA_W(16), .IO_W(8), .CH(2), .DEPTH(4)) dut (
        .CLK(clk), .AR(ar), .IOR(ior), .IOW(iow), .CH_SEL(ch_sel), .DATA(data_bus),
        .STALL(stall), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready), .IRQ(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ar = 1'b1; ior = 0; iow = 0; ch_sel = 0; tb_data = 0;
        in_data = 0; in_valid = 0; out_ready = 0;
        #1 ar = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall, 0);
        chk("rst_irq", irq, 0);
        tick();
        ar = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 2'b11);
        chk("post_rst_out_valid", out_valid, 0);

        // RX fill on ch1, then drain through the bus.
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'(8'h11 * (i + 1));
            in_data = {exp_b, 8'h00};
            in_valid = 2'b10;
            rxq.push_back(exp_b);
            #1 chk("rx_ready_fill", in_ready[1], 1);
            tick();
        end
        in_valid = 0;
        #1;
        chk("rx_full_ready1", in_ready[1], 0);
        chk("rx_other_ready0", in_ready[0], 1);
        ior = 1; ch_sel = 3'd1;
        for (int i = 0; i < 4; i++) begin
            #1 exp_b = rxq.pop_front();
            chk("rx_drain_stall", stall, 0);
            chk("rx_drain_data", data_bus, {8'h00, exp_b});
            tick();
        end
        #1;
        chk("rx_empty_stall", stall, 1);
        chk("rx_empty_data", data_bus, 0);
        ior = 0;
        tick();

        // TX backpressure on ch0.
        out_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            iow = 1; ch_sel = 3'd0; tb_data = 16'hAB00 | 16'(i);
            #1;
            if (i > 1) chk("tx_head_hold", out_data[7:0], txq[0]);
            if (i < 5) begin
                chk("tx_wr_stall", stall, 0);
                txq.push_back(8'(i));
            end else begin
                chk("tx_full_stall", stall, 1);
            end
            tick();
        end
        iow = 0;
        #1;
        chk("tx_valid0", out_valid, 2'b01);
        chk("tx_head", out_data[7:0], 8'h01);
        out_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1 exp_b = txq.pop_front();
            chk("tx_emit_valid", out_valid[0], 1);
            chk("tx_emit_data", out_data[7:0], exp_b);
            tick();
        end
        #1 chk("tx_drained", out_valid, 0);
        out_ready = 0;

        // Steady-state push+pop on ch0 RX at count 2; pointers wrap.
        for (int i = 0; i < 2; i++) begin
            exp_b = 8'hC0 + 8'(i);
            in_data = {8'h00, exp_b}; in_valid = 2'b01;
            rxq.push_back(exp_b);
            tick();
        end
        ior = 1; ch_sel = 3'd0;
        for (int i = 0; i < 10; i++) begin
            in_data = {8'h00, 8'hD0 + 8'(i)}; in_valid = 2'b01;
            rxq.push_back(8'hD0 + 8'(i));
            #1 exp_b = rxq.pop_front();
            chk("wrap_stall", stall, 0);
            chk("wrap_data", data_bus, {8'h00, exp_b});
            tick();
        end
        in_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #1 exp_b = rxq.pop_front();
            chk("wrap_tail_data", data_bus, {8'h00, exp_b});
            tick();
        end
        ior = 0;

        // Out-of-range channel and IOR+IOW conflict.
        in_data = 16'h005A; in_valid = 2'b01; rxq.push_back(8'h5A);
        tick();
        in_valid = 0;
        ior = 1; ch_sel = 3'd5;
        #1;
        chk("oor_rd_stall", stall, 0);
        chk("oor_rd_data", data_bus, 0);
        tick();
        iow = 1; ch_sel = 3'd0;
        #1 exp_b = rxq.pop_front();
        chk("conflict_data", data_bus, {8'h00, exp_b});
        chk("conflict_stall", stall, 0);
        tick();
        iow = 0;
        #1;
        chk("conflict_empty_stall", stall, 1);
        ior = 0;
        #1 chk("conflict_no_write", out_valid, 0);
        iow = 1; ch_sel = 3'd5; tb_data = 16'h0033;
        #1 chk("oor_wr_stall", stall, 0);
        tick();
        iow = 0;
        #1 chk("oor_wr_dropped", out_valid, 0);

        // IRQ: registered, one cycle behind the RX count.
        in_data = 16'h7700; in_valid = 2'b10; rxq.push_back(8'h77);
        tick();
        in_valid = 0;
        #1 chk("irq_lag", irq, 0);
        tick();
        chk("irq_set", irq, IRQ_EN ? 32'd1 : 32'd0);
        ior = 1; ch_sel = 3'd1;
        #1 exp_b = rxq.pop_front();
        chk("irq_pop_data", data_bus, {8'h00, exp_b});
        tick();
        ior = 0;
        #1 chk("irq_hold", irq, IRQ_EN ? 32'd1 : 32'd0);
        tick();
        chk("irq_clear", irq, 0);

        // Reset mid-transfer with FIFOs partly full.
        iow = 1; ch_sel = 3'd1;
        for (int i = 0; i < 2; i++) begin
            tb_data = 16'h0061 + 16'(i);
            tick();
        end
        iow = 0;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'h0090 + 16'(i); in_valid = 2'b01;
            tick();
        end
        in_data = 16'h0099; ior = 1; ch_sel = 3'd0;
        #1 ar = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_data", data_bus, 0);
        tick();
        ior = 0; in_valid = 0;
        ar = 1'b1;
        #1;
        chk("mid_rel_in_ready", in_ready, 2'b11);
        chk("mid_rel_out_valid", out_valid, 0);
        ior = 1; ch_sel = 3'd0;
        #1 chk("mid_rel_rx_empty", stall, 1);
        ior = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
